// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the IF stage (master) and instruction memory (slave).
// One request outstanding at a time; bits are numbered [0:31] with bit 0 the MSB.
interface instr_fetch_if;
  logic        IMemReq;
  logic [0:31] IMemAddr;
  logic        IMemAck;
  logic [0:31] IMemData;

  modport master (output IMemReq, IMemAddr, input  IMemAck, IMemData);
  modport slave  (input  IMemReq, IMemAddr, output IMemAck, IMemData);
endinterface

// File: rtl/instr_fetch.sv
// DLX IF stage: PC, single-outstanding imem handshake, stall/redirect handling, IF/ID register.
// Optional IFETCH_PERF_EN adds saturating FetchCount / StallCycles counters.
module instr_fetch #(
  parameter logic [0:31] RESET_PC  = 32'h00000000,
  parameter logic [0:31] NOP_INSTR = 32'h00000015
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [0:31]        RedirectPC,
  instr_fetch_if.master      imem,
  output logic [0:31]        IFID_Instr,
  output logic [0:31]        IFID_PCPlus4,
  output logic               IFID_Valid,
  output logic [0:5]         OpCode,
  output logic [0:5]         Function
`ifdef IFETCH_PERF_EN
  ,
  output logic [0:31]        FetchCount,
  output logic [0:31]        StallCycles
`endif
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state, state_nx;
  logic [0:31] pc, pc_nx, pend, pend_nx, buf_q, buf_nx, bufpc4, bufpc4_nx;
  logic [0:31] instr_nx, pc4_nx;
  logic        vld_nx, fetch_load;
  logic [0:31] rpc, pc_plus4;

  assign rpc      = {RedirectPC[0:29], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  assign imem.IMemReq  = (state == S_REQ) || (state == S_DRAIN);
  assign imem.IMemAddr = pc;
  assign OpCode        = IFID_Instr[0:5];
  assign Function      = IFID_Instr[26:31];

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pend_nx    = pend;
    buf_nx     = buf_q;
    bufpc4_nx  = bufpc4;
    instr_nx   = IFID_Instr;
    pc4_nx     = IFID_PCPlus4;
    vld_nx     = IFID_Valid;
    fetch_load = 1'b0;
    case (state)
      S_REQ: begin
        if (Redirect) begin
          instr_nx = NOP_INSTR; pc4_nx = '0; vld_nx = 1'b0;
          if (imem.IMemAck) pc_nx = rpc;
          else begin
            pend_nx  = rpc;
            state_nx = S_DRAIN;
          end
        end else if (imem.IMemAck) begin
          pc_nx = pc_plus4;
          if (Stall) begin
            buf_nx    = imem.IMemData;
            bufpc4_nx = pc_plus4;
            state_nx  = S_HOLD;
          end else begin
            instr_nx = imem.IMemData; pc4_nx = pc_plus4; vld_nx = 1'b1;
            fetch_load = 1'b1;
          end
        end else if (!Stall) begin
          instr_nx = NOP_INSTR; pc4_nx = '0; vld_nx = 1'b0;
        end
      end
      S_HOLD: begin
        // Ack is ignored here: no request is outstanding.
        if (Redirect) begin
          pc_nx    = rpc;
          instr_nx = NOP_INSTR; pc4_nx = '0; vld_nx = 1'b0;
          state_nx = S_REQ;
        end else if (!Stall) begin
          instr_nx = buf_q; pc4_nx = bufpc4; vld_nx = 1'b1;
          fetch_load = 1'b1;
          state_nx   = S_REQ;
        end
      end
      S_DRAIN: begin
        instr_nx = NOP_INSTR; pc4_nx = '0; vld_nx = 1'b0;
        if (imem.IMemAck) begin
          pc_nx    = Redirect ? rpc : pend;
          state_nx = S_REQ;
        end else if (Redirect) begin
          pend_nx = rpc;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      pend         <= '0;
      buf_q        <= '0;
      bufpc4       <= '0;
      IFID_Instr   <= NOP_INSTR;
      IFID_PCPlus4 <= '0;
      IFID_Valid   <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      pend         <= pend_nx;
      buf_q        <= buf_nx;
      bufpc4       <= bufpc4_nx;
      IFID_Instr   <= instr_nx;
      IFID_PCPlus4 <= pc4_nx;
      IFID_Valid   <= vld_nx;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      FetchCount  <= '0;
      StallCycles <= '0;
    end else begin
      if (fetch_load && (FetchCount != '1)) FetchCount <= FetchCount + 32'd1;
      if ((!IFID_Valid || Stall) && (StallCycles != '1)) StallCycles <= StallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, a RESET_PC wrap instance, and random
// stimulus against a queue-based reference model.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h00000015;

  logic        clk = 1'b0;
  logic        reset, Stall, Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] IFID_Instr, IFID_PCPlus4, IFID_Instr2, IFID_PCPlus42;
  logic        IFID_Valid, IFID_Valid2;
  logic [5:0]  OpCode, Function, OpCode2, Function2;
`ifdef IFETCH_PERF_EN
  logic [31:0] FetchCount, StallCycles, FetchCount2, StallCycles2;
`endif

  always #5 clk = ~clk;

  instr_fetch_if imem ();
  instr_fetch_if imem2 ();

  instr_fetch dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .imem(imem), .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .OpCode(OpCode), .Function(Function)
`ifdef IFETCH_PERF_EN
    , .FetchCount(FetchCount), .StallCycles(StallCycles)
`endif
  );

  // Second instance: fetch address wraps past 0xFFFFFFFC, memory acks every cycle.
  instr_fetch #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .reset(reset), .Stall(1'b0), .Redirect(1'b0), .RedirectPC(32'h0),
    .imem(imem2), .IFID_Instr(IFID_Instr2), .IFID_PCPlus4(IFID_PCPlus42), .IFID_Valid(IFID_Valid2),
    .OpCode(OpCode2), .Function(Function2)
`ifdef IFETCH_PERF_EN
    , .FetchCount(FetchCount2), .StallCycles(StallCycles2)
`endif
  );
  assign imem2.IMemAck  = 1'b1;
  assign imem2.IMemData = imem2.IMemAddr | 32'h00221800;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input logic [31:0] a);
    return a | 32'h00221800;
  endfunction

  typedef struct {
    logic rst, stall, redir; logic [31:0] rpc; logic ack; logic [31:0] data;
    logic req; logic [31:0] addr, instr, pc4; logic vld;
  } vec_t;

  function automatic vec_t v(input logic rst, stall, redir, input logic [31:0] rpc,
                             input logic ack, input logic [31:0] data, input logic req,
                             input logic [31:0] addr, instr, pc4, input logic vld);
    vec_t t;
    t.rst = rst; t.stall = stall; t.redir = redir; t.rpc = rpc; t.ack = ack; t.data = data;
    t.req = req; t.addr = addr; t.instr = instr; t.pc4 = pc4; t.vld = vld;
    return t;
  endfunction

  task automatic drive(input logic rst, stall, redir, input logic [31:0] rpc,
                       input logic ack, input logic [31:0] data);
    reset = rst; Stall = stall; Redirect = redir; RedirectPC = rpc;
    imem.IMemAck = ack; imem.IMemData = data;
    @(posedge clk);
    #1;
  endtask

  // Reference model: next fetch address, an in-flight request whose data is to be
  // discarded (with the address to resume at), and at most one buffered instruction.
  typedef struct { logic [31:0] i, p; } ent_t;
  logic [31:0] m_pc, m_tgt, m_instr, m_pc4;
  logic        m_drop, m_vld;
  ent_t        m_held[$];
  longint      m_fc, m_sc;

  task automatic m_bubble();
    m_instr = NOP; m_pc4 = 0; m_vld = 1'b0;
  endtask

  task automatic m_load(input logic [31:0] i, input logic [31:0] p);
    m_instr = i; m_pc4 = p; m_vld = 1'b1; m_fc++;
  endtask

  task automatic model_step(input logic rst, stall, redir, input logic [31:0] rpc,
                            input logic ack, input logic [31:0] data);
    logic [31:0] t;
    t = {rpc[31:2], 2'b00};
    if (!rst && (!m_vld || stall)) m_sc++;
    if (rst) begin
      m_pc = 32'h0; m_drop = 1'b0; m_held.delete(); m_bubble(); m_fc = 0; m_sc = 0;
    end else if (m_held.size() != 0) begin
      if (redir) begin m_held.delete(); m_pc = t; m_bubble(); end
      else if (!stall) begin ent_t e; e = m_held.pop_front(); m_load(e.i, e.p); end
    end else if (m_drop) begin
      m_bubble();
      if (redir) m_tgt = t;
      if (ack) begin m_pc = m_tgt; m_drop = 1'b0; end
    end else if (redir) begin
      m_bubble();
      if (ack) m_pc = t;
      else begin m_drop = 1'b1; m_tgt = t; end
    end else if (ack) begin
      if (stall) m_held.push_back('{data, m_pc + 32'd4});
      else m_load(data, m_pc + 32'd4);
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_bubble();
    end
  endtask

  vec_t tv[38];

  initial begin
    reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    imem.IMemAck = 1'b0; imem.IMemData = '0;

    tv[0]  = v(1,0,0,0,    0,0,          1,32'h0,  NOP,        0,        0);
    tv[1]  = v(0,0,0,0,    1,w(0),       1,32'h4,  w(0),       32'h4,    1);
    tv[2]  = v(0,0,0,0,    1,w(4),       1,32'h8,  w(4),       32'h8,    1);
    tv[3]  = v(0,1,0,0,    1,w(8),       0,32'hC,  w(4),       32'h8,    1);
    tv[4]  = v(0,1,0,0,    0,0,          0,32'hC,  w(4),       32'h8,    1);
    tv[5]  = v(0,1,0,0,    0,0,          0,32'hC,  w(4),       32'h8,    1);
    tv[6]  = v(0,0,0,0,    0,0,          1,32'hC,  w(8),       32'hC,    1);
    tv[7]  = v(0,0,0,0,    1,w(32'hC),   1,32'h10, w(32'hC),   32'h10,   1);
    tv[8]  = v(0,0,0,0,    0,0,          1,32'h10, NOP,        0,        0);
    tv[9]  = v(0,0,1,32'h103,0,0,        1,32'h10, NOP,        0,        0);
    tv[10] = v(0,0,0,0,    0,0,          1,32'h10, NOP,        0,        0);
    tv[11] = v(0,0,0,0,    1,w(32'h10),  1,32'h100,NOP,        0,        0);
    tv[12] = v(0,0,0,0,    1,w(32'h100), 1,32'h104,w(32'h100), 32'h104,  1);
    tv[13] = v(0,0,1,32'h40,1,w(32'h104),1,32'h40, NOP,        0,        0);
    tv[14] = v(0,0,0,0,    1,w(32'h40),  1,32'h44, w(32'h40),  32'h44,   1);
    tv[15] = v(0,0,1,32'h20,1,w(32'h44), 1,32'h20, NOP,        0,        0);
    tv[16] = v(0,0,0,0,    1,w(32'h20),  1,32'h24, w(32'h20),  32'h24,   1);
    tv[17] = v(0,0,0,0,    0,0,          1,32'h24, NOP,        0,        0);
    tv[18] = v(0,0,1,32'h80,0,0,         1,32'h24, NOP,        0,        0);
    tv[19] = v(1,0,0,0,    1,w(32'h24),  1,32'h0,  NOP,        0,        0);
    tv[20] = v(0,0,0,0,    1,w(0),       1,32'h4,  w(0),       32'h4,    1);
    tv[21] = v(0,1,0,0,    1,w(4),       0,32'h8,  w(0),       32'h4,    1);
    tv[22] = v(1,1,0,0,    0,0,          1,32'h0,  NOP,        0,        0);
    tv[23] = v(0,0,0,0,    0,0,          1,32'h0,  NOP,        0,        0);
    tv[24] = v(0,0,0,0,    1,w(0),       1,32'h4,  w(0),       32'h4,    1);
    tv[25] = v(0,0,0,0,    0,0,          1,32'h4,  NOP,        0,        0);
    tv[26] = v(0,0,1,32'h200,0,0,        1,32'h4,  NOP,        0,        0);
    tv[27] = v(0,1,1,32'h300,0,0,        1,32'h4,  NOP,        0,        0);
    tv[28] = v(0,0,1,32'h400,1,w(4),     1,32'h400,NOP,        0,        0);
    tv[29] = v(0,0,0,0,    1,w(32'h400), 1,32'h404,w(32'h400), 32'h404,  1);
    tv[30] = v(0,1,0,0,    0,0,          1,32'h404,w(32'h400), 32'h404,  1);
    tv[31] = v(0,1,0,0,    1,w(32'h404), 0,32'h408,w(32'h400), 32'h404,  1);
    tv[32] = v(0,1,0,0,    1,32'hDEADBEEF,0,32'h408,w(32'h400),32'h404,  1);
    tv[33] = v(0,1,1,32'h500,0,0,        1,32'h500,NOP,        0,        0);
    tv[34] = v(0,0,0,0,    1,w(32'h500), 1,32'h504,w(32'h500), 32'h504,  1);
    tv[35] = v(0,1,0,0,    0,0,          1,32'h504,w(32'h500), 32'h504,  1);
    tv[36] = v(0,0,0,0,    1,w(32'h504), 1,32'h508,w(32'h504), 32'h508,  1);
    tv[37] = v(0,0,0,0,    0,0,          1,32'h508,NOP,        0,        0);

    for (int i = 0; i < 38; i++) begin
      string tag;
      logic [31:0] ei;
      drive(tv[i].rst, tv[i].stall, tv[i].redir, tv[i].rpc, tv[i].ack, tv[i].data);
      tag = $sformatf("vec%0d", i);
      ei  = tv[i].instr;
      chk({tag, ".req"},   {31'b0, imem.IMemReq}, {31'b0, tv[i].req});
      chk({tag, ".addr"},  imem.IMemAddr, tv[i].addr);
      chk({tag, ".instr"}, IFID_Instr, ei);
      chk({tag, ".pc4"},   IFID_PCPlus4, tv[i].pc4);
      chk({tag, ".valid"}, {31'b0, IFID_Valid}, {31'b0, tv[i].vld});
      chk({tag, ".op"},    {26'b0, OpCode}, {26'b0, ei[31:26]});
      chk({tag, ".fn"},    {26'b0, Function}, {26'b0, ei[5:0]});
      if (i == 0) begin
        chk("wrap.rst_addr", imem2.IMemAddr, 32'hFFFFFFFC);
        chk("wrap.rst_req",  {31'b0, imem2.IMemReq}, 32'd1);
      end
      if (i == 1) begin
        chk("wrap.pc4",   IFID_PCPlus42, 32'h0);
        chk("wrap.addr",  imem2.IMemAddr, 32'h0);
        chk("wrap.instr", IFID_Instr2, 32'hFFFFFFFC);
        chk("wrap.valid", {31'b0, IFID_Valid2}, 32'd1);
`ifdef IFETCH_PERF_EN
        chk("wrap.fetchcount", FetchCount2, 32'd1);
`endif
      end
    end

    m_fc = 0; m_sc = 0;
    for (int c = 0; c < 3000; c++) begin
      logic rst, st, rd, ak;
      logic [31:0] rp, dt;
      rst = (c == 0) || ($urandom_range(99) < 2);
      st  = $urandom_range(99) < 30;
      rd  = $urandom_range(99) < 10;
      ak  = $urandom_range(99) < 60;
      rp  = $urandom;
      dt  = $urandom;
      drive(rst, st, rd, rp, ak, dt);
      model_step(rst, st, rd, rp, ak, dt);
      chk("rnd.req",   {31'b0, imem.IMemReq}, {31'b0, (m_held.size() == 0)});
      chk("rnd.addr",  imem.IMemAddr, m_pc);
      chk("rnd.instr", IFID_Instr, m_instr);
      chk("rnd.pc4",   IFID_PCPlus4, m_pc4);
      chk("rnd.valid", {31'b0, IFID_Valid}, {31'b0, m_vld});
`ifdef IFETCH_PERF_EN
      chk("rnd.fetchcount",  FetchCount, m_fc[31:0]);
      chk("rnd.stallcycles", StallCycles, m_sc[31:0]);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the pipelined DLX core, directly upstream of the control decoder.
- Holds the PC and runs a one-outstanding-request handshake with instruction memory.
- Applies stalls from the hazard unit and redirects from branch/jump resolution.
- Drives the IF/ID pipeline register, exposing OpCode/Function straight to the decoder.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset
NOP_INSTR, 32'h00000015, bubble word (OpCode 0x00, Function 0x15; no register write)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
Stall  in  1  ID cannot accept; hold IF/ID
Redirect  in  1  taken branch/jump resolved this cycle
RedirectPC  in  32  target; bits [30:31] ignored, treated as 00
IMemReq  out  1  fetch request; held high until IMemAck
IMemAddr  out  32  fetch address, stable while IMemReq=1
IMemAck  in  1  IMemData valid for the outstanding request
IMemData  in  32  instruction word
IFID_Instr  out  32  IF/ID instruction
IFID_PCPlus4  out  32  IF/ID fetch address + 4
IFID_Valid  out  1  IF/ID holds a real instruction
OpCode  out  6  IFID_Instr[0:5]
Function  out  6  IFID_Instr[26:31]

Behaviour:
- Bit order: [0:31], with bit 0 the MSB.
- Registers: PC (current fetch address), PendPC, Buf, BufPC4, and state in {REQ, HOLD, DRAIN}.
- IMemReq = (state==REQ | state==DRAIN). IMemAddr = PC.
- Reset (takes priority over everything):
  - PC=RESET_PC, state=REQ, IFID_Instr=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0.
  - First cycle after reset: IMemReq=1, IMemAddr=RESET_PC.
- Priority within a cycle: reset > Redirect > Stall.
- REQ state:
  - Redirect with IMemAck: drop data; PC<=RedirectPC; stay REQ.
  - Redirect without IMemAck: PendPC<=RedirectPC; go DRAIN.
  - In both Redirect cases: IF/ID <= {NOP_INSTR, 0, 0}.
  - IMemAck & !Stall: IF/ID <= {IMemData, PC+4, 1}; PC<=PC+4.
  - IMemAck & Stall: Buf<=IMemData, BufPC4<=PC+4, PC<=PC+4; go HOLD; IF/ID unchanged.
  - No ack & !Stall: IF/ID <= bubble {NOP_INSTR, 0, 0}.
  - No ack & Stall: IF/ID unchanged.
- HOLD state:
  - IMemReq=0.
  - Redirect: drop Buf; PC<=RedirectPC; flush IF/ID; go REQ.
  - Else !Stall: IF/ID <= {Buf, BufPC4, 1}; go REQ.
  - Else: stay in HOLD.
- DRAIN state:
  - IMemReq=1 at the old PC; the in-flight request must complete.
  - A further Redirect overwrites PendPC (newest wins).
  - IMemAck: data dropped; PC<=PendPC (or RedirectPC if Redirect in the same cycle); go REQ.
  - IF/ID stays a bubble regardless of Stall.
- Latency:
  - Ack in cycle N → IF/ID valid at N+1 (no stall).
  - With single-cycle ack: one instruction per cycle, new request issued the cycle after each ack.
  - Redirect → target address on IMemAddr next cycle (or after the drain ack).
- Arithmetic: PC+4 wraps modulo 2^32.
- At most one request outstanding. An IMemAck with IMemReq=0 is ignored.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds outputs FetchCount[32] and StallCycles[32], both 0 on reset, saturating at 0xFFFFFFFF.
  - FetchCount increments on each IF/ID load with valid=1.
  - StallCycles increments each cycle that IF/ID_Valid=0 after reset, or Stall=1 while IF/ID_Valid=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=0, memory acks every cycle with word=addr|0x00221800 -> IMemAddr 0,4,8,…; IFID_PCPlus4 4,8,12; at addr 0x20, OpCode=0x00 and Function=0x20.
- Stall=1 in the ack cycle for addr 0x8, held 3 cycles -> HOLD, IMemReq=0, IF/ID frozen; release -> IFID_Instr=word@0x8, PCPlus4=0xC, next IMemAddr=0xC.
- Request to 0x10 acked 3 cycles late, Redirect=1 to 0x103 during wait -> DRAIN, returned word discarded, next IMemAddr=0x100, IFID_Instr=0x00000015 with Valid=0 throughout.
- Redirect to 0x40 in the same cycle as IMemAck -> data dropped, next cycle IMemAddr=0x40, no DRAIN visit.
- Reset asserted mid-DRAIN and mid-HOLD -> next cycle IMemReq=1, IMemAddr=RESET_PC, IFID_Valid=0, pending/buffered data never appears.
- RESET_PC=0xFFFFFFFC -> first IFID_PCPlus4=0x00000000, next IMemAddr=0x00000000; with IFETCH_PERF_EN, FetchCount=1 after the first load.
